// File: rtl/prog_mem_pkg.sv
// Shared definitions for the program-memory arbiter: FSM state encoding and
// default address/data widths of the program RAM.
package prog_mem_pkg;
  localparam int AW_DEF = 8;
  localparam int DW_DEF = 12;

  localparam logic [1:0] ST_ARB         = 2'd0;
  localparam logic [1:0] ST_LOCKED      = 2'd1;
  localparam logic [1:0] ST_RELOCK_WAIT = 2'd2;
endpackage

// File: rtl/prog_mem_arbiter_rr_arb2.sv
// Two-way round-robin picker; index 0 is instruction fetch, index 1 is host.
// Remembers the last winner and favours the other side on a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  input  logic       park,
  output logic [1:0] gnt
);
  // last winner index; host-last out of reset so fetch wins the first tie
  logic last;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last <= 1'b1;
    else if (park)   last <= 1'b1;
    else if (gnt[0]) last <= 1'b0;
    else if (gnt[1]) last <= 1'b1;
  end
endmodule

// File: rtl/prog_mem_arbiter.sv
// Shares a single-port synchronous program RAM between CPU fetch and a host
// loader port, with host lock, CPU stall and a lock-duration watchdog.
module prog_mem_arbiter
  import prog_mem_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int LOCK_MAX = 256
) (
  input  logic          clk,
  input  logic          CLB,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [DW-1:0] f_rdata,
  input  logic          h_req,
  input  logic          h_we,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  input  logic          h_lock,
  output logic          h_gnt,
  output logic          h_rvalid,
  output logic [DW-1:0] h_rdata,
  output logic          cpu_hold,
  output logic          lock_to,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  localparam int            CW       = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] lock_cnt;
  logic [1:0]    arb_gnt;
  logic          locked, arb_en, cnt_last, park;

  assign locked   = (state == ST_LOCKED);
  assign arb_en   = !CLB && !locked;
  assign cnt_last = locked && h_lock && (lock_cnt == CNT_LAST);
  // leaving LOCKED always hands the next tie to the stalled fetch side
  assign park     = locked && (!h_lock || cnt_last);

  rr_arb2 u_rr (
    .clk  (clk),
    .rst  (CLB),
    .req  ({h_req, f_req}),
    .en   (arb_en),
    .park (park),
    .gnt  (arb_gnt)
  );

  // p0: combinational grant and RAM command
  assign f_gnt     = arb_gnt[0];
  assign h_gnt     = locked ? h_req : arb_gnt[1];
  assign lock_to   = cnt_last;
  assign cpu_hold  = locked || (h_gnt && h_lock && (state != ST_RELOCK_WAIT));
  assign mem_en    = f_gnt || h_gnt;
  assign mem_we    = h_gnt && h_we;
  assign mem_addr  = h_gnt ? h_addr : (f_gnt ? f_addr : '0);
  assign mem_wdata = (h_gnt && h_we) ? h_wdata : '0;
  assign f_rdata   = mem_rdata;
  assign h_rdata   = mem_rdata;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_ARB:         if (h_gnt && h_lock) state_nxt = ST_LOCKED;
      ST_LOCKED:      if (!h_lock)         state_nxt = ST_ARB;
                      else if (cnt_last)   state_nxt = ST_RELOCK_WAIT;
      ST_RELOCK_WAIT: if (!h_lock)         state_nxt = ST_ARB;
      default:                             state_nxt = ST_ARB;
    endcase
  end

  // p1: read-valid flags aligned with the RAM's one-cycle read latency
  always_ff @(posedge clk or posedge CLB) begin
    if (CLB) begin
      state    <= ST_ARB;
      lock_cnt <= '0;
      f_rvalid <= 1'b0;
      h_rvalid <= 1'b0;
    end else begin
      state    <= state_nxt;
      f_rvalid <= f_gnt;
      h_rvalid <= h_gnt && !h_we;
      lock_cnt <= locked ? lock_cnt + CW'(1) : '0;
    end
  end
endmodule

// File: tb/tb_prog_mem_arbiter.sv
// Scenario bench for prog_mem_arbiter: behavioural RAM, shadow memory and
// read-data queues filled on expected grants and drained on rvalid.
module tb_prog_mem_arbiter;
  localparam int LM = 20;

  logic        clk = 1'b0;
  logic        CLB = 1'b1;
  logic        f_req = 1'b0, h_req = 1'b0, h_we = 1'b0, h_lock = 1'b0;
  logic [7:0]  f_addr = '0, h_addr = '0;
  logic [11:0] h_wdata = '0;
  logic        f_gnt, f_rvalid, h_gnt, h_rvalid, cpu_hold, lock_to, mem_en, mem_we;
  logic [11:0] f_rdata, h_rdata, mem_wdata;
  logic [7:0]  mem_addr;
  logic [11:0] mem_rdata = '0;

  logic [11:0] ram [256];
  logic [255:0] touched = '0;
  logic [11:0] shadow [256];
  logic [11:0] fq[$];
  logic [11:0] hq[$];
  int total = 0;
  int bad = 0;

  prog_mem_arbiter #(.AW(8), .DW(12), .LOCK_MAX(LM)) dut (
    .clk(clk), .CLB(CLB),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata), .h_lock(h_lock),
    .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
    .cpu_hold(cpu_hold), .lock_to(lock_to),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] init_word(input logic [7:0] a);
    return {a[3:0], ~a} ^ 12'h35A;
  endfunction

  // single-port synchronous RAM, one-cycle read latency
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr]     <= mem_wdata;
        touched[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= touched[mem_addr] ? ram[mem_addr] : init_word(mem_addr);
      end
    end
  end

  always @(negedge clk) begin
    if (f_rvalid) begin
      total++;
      if (fq.size() == 0) begin
        bad++;
        $display("FAIL f_rvalid_unexpected got=1 want=0 t=%0t", $time);
      end else begin
        logic [11:0] e;
        e = fq.pop_front();
        if (f_rdata !== e) begin
          bad++;
          $display("FAIL f_rdata got=%h want=%h t=%0t", f_rdata, e, $time);
        end
      end
    end
    if (h_rvalid) begin
      total++;
      if (hq.size() == 0) begin
        bad++;
        $display("FAIL h_rvalid_unexpected got=1 want=0 t=%0t", $time);
      end else begin
        logic [11:0] e;
        e = hq.pop_front();
        if (h_rdata !== e) begin
          bad++;
          $display("FAIL h_rdata got=%h want=%h t=%0t", h_rdata, e, $time);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    f_req = 1'b0; h_req = 1'b0; h_we = 1'b0; h_lock = 1'b0;
  endtask

  task automatic drain(input string name);
    cyc();
    idle();
    @(negedge clk);
    #1;
    total++;
    if (fq.size() != 0 || hq.size() != 0) begin
      bad++;
      $display("FAIL %s_drain pending f=%0d h=%0d want 0/0", name, fq.size(), hq.size());
      fq.delete();
      hq.delete();
    end
  endtask

  task automatic test_reset();
    idle();
    CLB = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    CLB = 1'b0;
    f_req = 1'b1; f_addr = 8'h03;
    @(negedge clk);
    total++;
    if (f_gnt !== 1'b1 || mem_addr !== 8'h03) begin
      bad++;
      $display("FAIL reset_first_fetch gnt=%b addr=%h want 1/03", f_gnt, mem_addr);
    end
    fq.push_back(shadow[8'h03]);
    cyc();
    CLB = 1'b1;
    fq.delete();
    f_addr = 8'h04;
    #1;
    total++;
    if ({f_gnt, h_gnt, f_rvalid, h_rvalid, cpu_hold, lock_to, mem_en, mem_we} !== 8'h00 ||
        mem_addr !== 8'h00 || mem_wdata !== 12'h000) begin
      bad++;
      $display("FAIL reset_outputs flags=%b addr=%h wdata=%h want 0", {f_gnt, h_gnt, f_rvalid,
               h_rvalid, cpu_hold, lock_to, mem_en, mem_we}, mem_addr, mem_wdata);
    end
    cyc();
    CLB = 1'b0;
    @(negedge clk);
    total++;
    if (f_gnt !== 1'b1 || mem_addr !== 8'h04) begin
      bad++;
      $display("FAIL reset_release_fetch gnt=%b addr=%h want 1/04", f_gnt, mem_addr);
    end
    fq.push_back(shadow[8'h04]);
    drain("reset");
  endtask

  task automatic test_round_robin();
    int fc = 0;
    int hc = 0;
    cyc();
    h_req = 1'b1; h_we = 1'b0; h_addr = 8'h40;
    @(negedge clk);
    total++;
    if (h_gnt !== 1'b1 || f_gnt !== 1'b0) begin
      bad++;
      $display("FAIL rr_host_alone f=%b h=%b want 0/1", f_gnt, h_gnt);
    end
    hq.push_back(shadow[8'h40]);
    for (int i = 0; i < 4; i++) begin
      logic ef;
      logic [7:0] ea;
      cyc();
      f_req = 1'b1; f_addr = 8'(8'h20 + fc);
      h_req = 1'b1; h_addr = 8'(8'h41 + hc);
      ef = (i % 2 == 0);
      ea = ef ? f_addr : h_addr;
      @(negedge clk);
      total++;
      if (f_gnt !== ef || h_gnt !== !ef || mem_addr !== ea || mem_we !== 1'b0) begin
        bad++;
        $display("FAIL rr_alt_%0d f=%b h=%b addr=%h want f=%b h=%b addr=%h",
                 i, f_gnt, h_gnt, mem_addr, ef, !ef, ea);
      end
      if (ef) begin
        fq.push_back(shadow[f_addr]);
        fc++;
      end else begin
        hq.push_back(shadow[h_addr]);
        hc++;
      end
    end
    drain("rr");
  endtask

  task automatic test_lock_load();
    cyc();
    f_req = 1'b0;
    h_req = 1'b1; h_we = 1'b1; h_lock = 1'b1; h_addr = 8'h00; h_wdata = 12'h0D5;
    @(negedge clk);
    total++;
    if (h_gnt !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 12'h0D5 || cpu_hold !== 1'b1) begin
      bad++;
      $display("FAIL lock_enter h=%b we=%b wd=%h hold=%b want 1/1/0d5/1",
               h_gnt, mem_we, mem_wdata, cpu_hold);
    end
    shadow[8'h00] = 12'h0D5;
    for (int i = 1; i < 16; i++) begin
      cyc();
      h_addr = 8'(i);
      f_req = 1'b1; f_addr = 8'h50;
      @(negedge clk);
      total++;
      if (h_gnt !== 1'b1 || f_gnt !== 1'b0 || cpu_hold !== 1'b1 || mem_we !== 1'b1 ||
          mem_addr !== 8'(i)) begin
        bad++;
        $display("FAIL lock_write_%0d h=%b f=%b hold=%b we=%b addr=%h want 1/0/1/1/%h",
                 i, h_gnt, f_gnt, cpu_hold, mem_we, mem_addr, 8'(i));
      end
      shadow[i] = 12'h0D5;
    end
    cyc();
    h_lock = 1'b0; h_we = 1'b0; h_addr = 8'h05;
    @(negedge clk);
    total++;
    if (h_gnt !== 1'b1 || f_gnt !== 1'b0 || cpu_hold !== 1'b1) begin
      bad++;
      $display("FAIL lock_drop h=%b f=%b hold=%b want 1/0/1", h_gnt, f_gnt, cpu_hold);
    end
    hq.push_back(shadow[8'h05]);
    cyc();
    h_addr = 8'h0F;
    @(negedge clk);
    total++;
    if (f_gnt !== 1'b1 || h_gnt !== 1'b0 || cpu_hold !== 1'b0 || mem_addr !== 8'h50) begin
      bad++;
      $display("FAIL lock_fetch_after f=%b h=%b hold=%b addr=%h want 1/0/0/50",
               f_gnt, h_gnt, cpu_hold, mem_addr);
    end
    fq.push_back(shadow[8'h50]);
    cyc();
    f_req = 1'b0;
    @(negedge clk);
    total++;
    if (h_gnt !== 1'b1 || f_gnt !== 1'b0) begin
      bad++;
      $display("FAIL lock_host_after f=%b h=%b want 0/1", f_gnt, h_gnt);
    end
    hq.push_back(shadow[8'h0F]);
    drain("lock");
  endtask

  task automatic test_watchdog();
    cyc();
    f_req = 1'b0;
    h_req = 1'b1; h_we = 1'b0; h_lock = 1'b1; h_addr = 8'h60;
    @(negedge clk);
    total++;
    if (h_gnt !== 1'b1 || cpu_hold !== 1'b1 || lock_to !== 1'b0) begin
      bad++;
      $display("FAIL wd_enter h=%b hold=%b to=%b want 1/1/0", h_gnt, cpu_hold, lock_to);
    end
    hq.push_back(shadow[8'h60]);
    for (int j = 1; j <= LM; j++) begin
      cyc();
      h_req = 1'b0; f_req = 1'b1; f_addr = 8'h61;
      @(negedge clk);
      total++;
      if (f_gnt !== 1'b0 || cpu_hold !== 1'b1 || lock_to !== (j == LM)) begin
        bad++;
        $display("FAIL wd_cycle_%0d f=%b hold=%b to=%b want 0/1/%b",
                 j, f_gnt, cpu_hold, lock_to, (j == LM));
      end
    end
    cyc();
    h_req = 1'b1; h_addr = 8'h62;
    @(negedge clk);
    total++;
    if (f_gnt !== 1'b1 || h_gnt !== 1'b0 || lock_to !== 1'b0 || cpu_hold !== 1'b0) begin
      bad++;
      $display("FAIL wd_fetch f=%b h=%b to=%b hold=%b want 1/0/0/0",
               f_gnt, h_gnt, lock_to, cpu_hold);
    end
    fq.push_back(shadow[8'h61]);
    for (int k = 0; k < 2; k++) begin
      cyc();
      f_req = 1'b0; h_addr = 8'(8'h62 + k);
      @(negedge clk);
      total++;
      if (h_gnt !== 1'b1 || cpu_hold !== 1'b0) begin
        bad++;
        $display("FAIL wd_no_relock_%0d h=%b hold=%b want 1/0", k, h_gnt, cpu_hold);
      end
      hq.push_back(shadow[h_addr]);
    end
    cyc();
    h_req = 1'b0; h_lock = 1'b0;
    @(negedge clk);
    cyc();
    h_req = 1'b1; h_lock = 1'b1; h_addr = 8'h64;
    @(negedge clk);
    total++;
    if (h_gnt !== 1'b1 || cpu_hold !== 1'b1) begin
      bad++;
      $display("FAIL wd_relock h=%b hold=%b want 1/1", h_gnt, cpu_hold);
    end
    hq.push_back(shadow[8'h64]);
    cyc();
    h_req = 1'b0; h_lock = 1'b0;
    @(negedge clk);
    total++;
    if (cpu_hold !== 1'b1) begin
      bad++;
      $display("FAIL wd_relocked_hold got=%b want 1", cpu_hold);
    end
    cyc();
    @(negedge clk);
    total++;
    if (cpu_hold !== 1'b0) begin
      bad++;
      $display("FAIL wd_released_hold got=%b want 0", cpu_hold);
    end
    drain("wd");
  endtask

  task automatic test_fetch_then_lock();
    cyc();
    f_req = 1'b1; f_addr = 8'h33;
    @(negedge clk);
    total++;
    if (f_gnt !== 1'b1) begin
      bad++;
      $display("FAIL ftl_fetch got=%b want 1", f_gnt);
    end
    fq.push_back(shadow[8'h33]);
    cyc();
    f_req = 1'b0;
    h_req = 1'b1; h_we = 1'b1; h_lock = 1'b1; h_addr = 8'h33; h_wdata = 12'hABC;
    @(negedge clk);
    total++;
    if (h_gnt !== 1'b1 || cpu_hold !== 1'b1 || f_rvalid !== 1'b1) begin
      bad++;
      $display("FAIL ftl_lock h=%b hold=%b f_rvalid=%b want 1/1/1", h_gnt, cpu_hold, f_rvalid);
    end
    shadow[8'h33] = 12'hABC;
    cyc();
    h_req = 1'b0; h_lock = 1'b0; h_we = 1'b0;
    @(negedge clk);
    total++;
    if (cpu_hold !== 1'b1 || h_gnt !== 1'b0) begin
      bad++;
      $display("FAIL ftl_unlock hold=%b h=%b want 1/0", cpu_hold, h_gnt);
    end
    cyc();
    f_req = 1'b1; f_addr = 8'h33;
    @(negedge clk);
    total++;
    if (f_gnt !== 1'b1 || cpu_hold !== 1'b0) begin
      bad++;
      $display("FAIL ftl_refetch f=%b hold=%b want 1/0", f_gnt, cpu_hold);
    end
    fq.push_back(shadow[8'h33]);
    drain("ftl");
  endtask

  task automatic test_back_to_back();
    cyc();
    h_req = 1'b1; h_we = 1'b1; h_addr = 8'h77; h_wdata = 12'h9E1;
    @(negedge clk);
    total++;
    if (h_gnt !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 12'h9E1) begin
      bad++;
      $display("FAIL b2b_write h=%b we=%b wd=%h want 1/1/9e1", h_gnt, mem_we, mem_wdata);
    end
    shadow[8'h77] = 12'h9E1;
    cyc();
    h_we = 1'b0;
    @(negedge clk);
    total++;
    if (h_gnt !== 1'b1 || mem_we !== 1'b0 || h_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_read h=%b we=%b h_rvalid=%b want 1/0/0", h_gnt, mem_we, h_rvalid);
    end
    hq.push_back(shadow[8'h77]);
    cyc();
    h_req = 1'b0;
    @(negedge clk);
    total++;
    if (h_rvalid !== 1'b1 || h_rdata !== 12'h9E1) begin
      bad++;
      $display("FAIL b2b_readback rvalid=%b data=%h want 1/9e1", h_rvalid, h_rdata);
    end
    drain("b2b");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = init_word(8'(i));
    test_reset();
    test_round_robin();
    test_lock_load();
    test_watchdog();
    test_fetch_then_lock();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached t=%0t want finish earlier", $time);
    $fatal(1, "bench time limit");
  end
endmodule
